// File: rtl/mul32fp_result_fifo.sv
// mul32fp_result_fifo
//   Result buffer behind multiplier32FP. Captures one product plus its four
//   exception flags per done pulse into a first-word-fall-through FIFO and
//   hands them to the consumer over valid/ready. Also keeps sticky exception
//   status and a saturating count of results lost to a full FIFO.
//
//   Build option: define MUL32FP_FIFO_FTZ_EN to flush underflowed products
//   to a signed zero as they are written. Default build stores them as-is.
module mul32fp_result_fifo #(
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned AFULL_LVL = DEPTH - 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         done_i,
   input  logic [31:0]                  product_i,
   input  logic                         nan_i,
   input  logic                         infinit_i,
   input  logic                         overflow_i,
   input  logic                         underflow_i,
   output logic [31:0]                  data_o,
   output logic [3:0]                   flags_o,
   output logic                         valid_o,
   input  logic                         ready_i,
   output logic                         full_o,
   output logic                         afull_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o,
   output logic [3:0]                   sticky_o,
   input  logic                         clr_sticky_i,
   output logic [7:0]                   drop_cnt_o
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LVL);

   // Entry layout: {product[31:0], nan, infinit, overflow, underflow}
   logic [35:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count_q;
   logic [3:0]    sticky_q;
   logic [7:0]    drop_q;
   logic          done_q;

   logic          cap;
   logic          push;
   logic          pop;
   logic          drop;
   logic          full;
   logic [3:0]    cap_flags;
   logic [31:0]   cap_data;
   logic [35:0]   head;

   // Handshake decode: edge-detected capture, pop, push and overflow drop
   always_comb begin
      cap       = done_i & ~done_q;
      full      = (count_q == DEPTH_C);
      pop       = (count_q != '0) & ready_i;
      push      = cap & (~full | pop);
      drop      = cap & full & ~pop;
      cap_flags = {nan_i, infinit_i, overflow_i, underflow_i};
`ifdef MUL32FP_FIFO_FTZ_EN
      cap_data  = underflow_i ? {product_i[31], 31'b0} : product_i;
`else
      cap_data  = product_i;
`endif
   end

   // done_q resets high so a done_i already asserted through reset is not
   // taken as a fresh pulse.
   always_ff @(posedge clk) begin
      if (rst) done_q <= 1'b1;
      else     done_q <= done_i;
   end

   // Storage array; contents are don't-care after reset, so no reset here
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {cap_data, cap_flags};
   end

   // Pointers and occupancy; pointers wrap naturally as DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         unique case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Sticky exception status; a same-cycle clear keeps only the new flags
   always_ff @(posedge clk) begin
      if (rst)               sticky_q <= '0;
      else if (clr_sticky_i) sticky_q <= cap ? cap_flags : 4'b0000;
      else if (cap)          sticky_q <= sticky_q | cap_flags;
   end

   // Saturating count of captures discarded because the FIFO was full
   always_ff @(posedge clk) begin
      if (rst)                          drop_q <= '0;
      else if (drop && drop_q != '1)    drop_q <= drop_q + 8'd1;
   end

   // Head presentation and status derived from registered state only
   always_comb begin
      head       = mem[rd_ptr];
      data_o     = head[35:4];
      flags_o    = head[3:0];
      valid_o    = (count_q != '0);
      full_o     = full;
      afull_o    = (count_q >= AFULL_C);
      count_o    = count_q;
      sticky_o   = sticky_q;
      drop_cnt_o = drop_q;
   end

endmodule

// File: tb/tb_mul32fp_result_fifo.sv
// Scoreboard bench for mul32fp_result_fifo (DEPTH=8, AFULL_LVL=6).
// Stimulus pushes the expected stored entry when a capture should be
// accepted; a negedge monitor pops and compares on every transfer.
module tb_mul32fp_result_fifo;

   logic        clk = 1'b0;
   logic        rst;
   logic        done_i;
   logic [31:0] product_i;
   logic        nan_i, infinit_i, overflow_i, underflow_i;
   logic [31:0] data_o;
   logic [3:0]  flags_o;
   logic        valid_o;
   logic        ready_i;
   logic        full_o;
   logic        afull_o;
   logic [3:0]  count_o;
   logic [3:0]  sticky_o;
   logic        clr_sticky_i;
   logic [7:0]  drop_cnt_o;

   int n_tests = 0;
   int n_fail  = 0;
   logic [35:0] exp_q [$];

   mul32fp_result_fifo #(.DEPTH(8), .AFULL_LVL(6)) dut (
      .clk          (clk),
      .rst          (rst),
      .done_i       (done_i),
      .product_i    (product_i),
      .nan_i        (nan_i),
      .infinit_i    (infinit_i),
      .overflow_i   (overflow_i),
      .underflow_i  (underflow_i),
      .data_o       (data_o),
      .flags_o      (flags_o),
      .valid_o      (valid_o),
      .ready_i      (ready_i),
      .full_o       (full_o),
      .afull_o      (afull_o),
      .count_o      (count_o),
      .sticky_o     (sticky_o),
      .clr_sticky_i (clr_sticky_i),
      .drop_cnt_o   (drop_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Expected stored product for a capture
   function automatic logic [31:0] stored(input logic [31:0] p, input logic [3:0] f);
`ifdef MUL32FP_FIFO_FTZ_EN
      if (f[0]) return {p[31], 31'b0};
`endif
      return p;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [31:0] p, input logic [3:0] f);
      product_i   = p;
      nan_i       = f[3];
      infinit_i   = f[2];
      overflow_i  = f[1];
      underflow_i = f[0];
   endtask

   // One done pulse of len cycles; acc says whether the FIFO should take it
   task automatic capture(input logic [31:0] p, input logic [3:0] f, input int len, input bit acc);
      set_in(p, f);
      if (acc) exp_q.push_back({stored(p, f), f});
      done_i = 1'b1;
      repeat (len) tick;
      done_i = 1'b0;
      tick;
   endtask

   task automatic drain(input string name);
      bit ok;
      ok = 1'b0;
      ready_i = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (!valid_o) begin
            ok = 1'b1;
            break;
         end
         tick;
      end
      ready_i = 1'b0;
      check({name, "_drained"}, {31'b0, ok}, 32'd1);
      check({name, "_count0"}, {28'b0, count_o}, 32'd0);
   endtask

   // Monitor: every transfer must match the head of the expected queue
   initial begin
      logic [35:0] e;
      forever begin
         @(negedge clk);
         if (!rst && valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
               check("unexpected_pop", {data_o}, 32'hxxxxxxxx);
            end else begin
               e = exp_q.pop_front();
               check("pop_data", data_o, e[35:4]);
               check("pop_flags", {28'b0, flags_o}, {28'b0, e[3:0]});
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; done_i = 1'b0; ready_i = 1'b0; clr_sticky_i = 1'b0;
      set_in(32'h0, 4'b0000);
      tick; tick;
      rst = 1'b0;
      tick;
      check("rst_count",  {28'b0, count_o}, 32'd0);
      check("rst_valid",  {31'b0, valid_o}, 32'd0);
      check("rst_full",   {31'b0, full_o}, 32'd0);
      check("rst_afull",  {31'b0, afull_o}, 32'd0);
      check("rst_sticky", {28'b0, sticky_o}, 32'd0);
      check("rst_drop",   {24'b0, drop_cnt_o}, 32'd0);

      // 3-cycle done pulse gives exactly one entry, visible one cycle later
      set_in(32'h40C00000, 4'b0000);
      exp_q.push_back({32'h40C00000, 4'b0000});
      done_i = 1'b1;
      tick;
      check("fwft_valid", {31'b0, valid_o}, 32'd1);
      check("fwft_data",  data_o, 32'h40C00000);
      check("fwft_flags", {28'b0, flags_o}, 32'd0);
      tick; tick;
      done_i = 1'b0;
      tick;
      check("one_per_pulse", {28'b0, count_o}, 32'd1);
      ready_i = 1'b1;
      tick;
      ready_i = 1'b0;
      check("pop_count0", {28'b0, count_o}, 32'd0);

      // Fill to full with ready low; 9th capture is dropped
      for (int i = 0; i < 9; i++) begin
         capture(32'h3F800000 + i, 4'b0000, 1, i < 8);
         if (i == 4) check("afull_below", {31'b0, afull_o}, 32'd0);
         if (i == 5) check("afull_at",    {31'b0, afull_o}, 32'd1);
         if (i == 6) check("full_early",  {31'b0, full_o}, 32'd0);
         if (i == 7) check("full_at8",    {31'b0, full_o}, 32'd1);
      end
      check("drop_one",   {24'b0, drop_cnt_o}, 32'd1);
      check("full_count", {28'b0, count_o}, 32'd8);

      // Full with simultaneous capture and pop
      set_in(32'h12345678, 4'b0000);
      exp_q.push_back({32'h12345678, 4'b0000});
      done_i = 1'b1; ready_i = 1'b1;
      tick;
      done_i = 1'b0; ready_i = 1'b0;
      check("pushpop_count", {28'b0, count_o}, 32'd8);
      check("pushpop_head",  data_o, 32'h3F800001);
      check("pushpop_drop",  {24'b0, drop_cnt_o}, 32'd1);
      tick;
      drain("drain_full");
      check("drain_queue", exp_q.size(), 32'd0);

      // Sticky accumulate, clear, and clear-with-capture
      ready_i = 1'b1;
      capture(32'h7F800000, 4'b0100, 1, 1'b1);
      capture(32'h7FC00000, 4'b1000, 1, 1'b1);
      check("sticky_or", {28'b0, sticky_o}, 32'b1100);
      clr_sticky_i = 1'b1;
      tick;
      clr_sticky_i = 1'b0;
      check("sticky_clr", {28'b0, sticky_o}, 32'd0);
      set_in(32'h7F7FFFFF, 4'b0010);
      exp_q.push_back({32'h7F7FFFFF, 4'b0010});
      clr_sticky_i = 1'b1; done_i = 1'b1;
      tick;
      clr_sticky_i = 1'b0; done_i = 1'b0;
      check("sticky_clr_cap", {28'b0, sticky_o}, 32'b0010);
      tick;
      drain("drain_sticky");

      // Underflowed product: flushed only in the FTZ build
      capture(32'h80000001, 4'b0001, 1, 1'b1);
      check("ftz_data",   data_o, stored(32'h80000001, 4'b0001));
      check("ftz_flags",  {28'b0, flags_o}, 32'b0001);
      check("ftz_sticky", {28'b0, sticky_o}, 32'b0011);
      drain("drain_ftz");

      // Drop counter saturation
      for (int i = 0; i < 8; i++) capture(32'hA0000000 + i, 4'b0000, 1, 1'b1);
      for (int i = 0; i < 254; i++) capture(32'hDEAD0000, 4'b0000, 1, 1'b0);
      check("drop_255", {24'b0, drop_cnt_o}, 32'd255);
      for (int i = 0; i < 2; i++) capture(32'hDEAD0001, 4'b0000, 1, 1'b0);
      check("drop_sat", {24'b0, drop_cnt_o}, 32'd255);
      drain("drain_sat");

      // Reset with 3 entries stored and done_i held high
      capture(32'h40000000, 4'b0000, 1, 1'b1);
      capture(32'h40400000, 4'b0000, 1, 1'b1);
      set_in(32'h40800000, 4'b0000);
      done_i = 1'b1;
      tick;
      check("pre_rst_count", {28'b0, count_o}, 32'd3);
      rst = 1'b1;
      tick; tick;
      exp_q.delete();
      rst = 1'b0;
      tick;
      check("post_rst_count",  {28'b0, count_o}, 32'd0);
      check("post_rst_valid",  {31'b0, valid_o}, 32'd0);
      check("post_rst_drop",   {24'b0, drop_cnt_o}, 32'd0);
      check("post_rst_sticky", {28'b0, sticky_o}, 32'd0);
      tick; tick;
      check("held_done_nocap", {28'b0, count_o}, 32'd0);
      done_i = 1'b0;
      tick;
      capture(32'h41000000, 4'b0000, 1, 1'b1);
      check("recap_count", {28'b0, count_o}, 32'd1);
      drain("drain_final");
      check("final_queue", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mul32fp_result_fifo.md
Name: mul32fp_result_fifo

Overview:
- Downstream stage of multiplier32FP. Captures each completed product and its four exception flags on the multiplier's done pulse.
- Buffers results in a first-word-fall-through FIFO and presents them to the consumer over a valid/ready handshake.
- Drives a full indication that upstream control uses to gate start_i.
- Keeps sticky exception status and a saturating count of dropped results.

Parameters:
- DEPTH, 8, number of FIFO entries; power of two, >= 2.
- AFULL_LVL, DEPTH-2, occupancy at or above which afull_o asserts.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- done_i  in  1  multiplier done_o; level pulse of one or more cycles.
- product_i  in  32  multiplier product_o (IEEE-754 single).
- nan_i  in  1  multiplier nan_o.
- infinit_i  in  1  multiplier infinit_o.
- overflow_i  in  1  multiplier overflow_o.
- underflow_i  in  1  multiplier underflow_o.
- data_o  out  32  head-of-FIFO product.
- flags_o  out  4  head flags, packed {nan, infinit, overflow, underflow}.
- valid_o  out  1  head entry valid.
- ready_i  in  1  consumer accepts head.
- full_o  out  1  occupancy == DEPTH.
- afull_o  out  1  occupancy >= AFULL_LVL.
- count_o  out  $clog2(DEPTH+1)  current occupancy.
- sticky_o  out  4  OR of the flags of every captured result since the last clear.
- clr_sticky_i  in  1  clears sticky_o.
- drop_cnt_o  out  8  number of results lost to a full FIFO; saturates at 255.

Behaviour:
- Reset (rst=1 at a clock edge):
  - Write and read pointers, count_o, sticky_o and drop_cnt_o go to 0.
  - valid_o=0, full_o=0, afull_o=0.
  - data_o and flags_o read the entry at pointer 0; their contents are don't-care.
  - The internal done_q register goes to 1, so a done_i held high through reset is not captured.
  - A reset mid-transfer discards all stored entries.
- Capture event: cap = done_i & ~done_q, with done_q <= done_i every cycle. Exactly one capture per done pulse, regardless of pulse length.
- Push: push = cap & (~full | pop).
  - The entry written is {product_i, nan_i, infinit_i, overflow_i, underflow_i}, sampled in the cap cycle.
- Pop: pop = valid_o & ready_i. The head advances at the next edge.
- FWFT timing:
  - valid_o = (count_o != 0).
  - A push into an empty FIFO gives valid_o=1 and data_o=pushed value on the cycle after the cap edge (1-cycle latency).
- Simultaneous push and pop:
  - When full: both occur and count is unchanged.
  - When empty: pop is impossible (valid_o=0), so only the push occurs.
- Occupancy and pointers:
  - count_o changes by +1 (push only), -1 (pop only) or 0.
  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Overflow (cap & full & ~pop):
  - The result is discarded and the FIFO is unchanged.
  - drop_cnt_o increments, saturating at 255.
- Sticky status:
  - sticky_o |= captured flags on every cap, including dropped captures.
  - clr_sticky_i=1 sets sticky_o to 0. If cap occurs in the same cycle, sticky_o takes the new flags only (clear has priority over the old value, not the new flags).
- Outputs full_o, afull_o and count_o are registered-derived (no combinational path from ready_i or done_i).
- ready_i is not used while valid_o=0.

Optional Feature:
- Macro: MUL32FP_FIFO_FTZ_EN.
- Defined: flush-to-zero on write.
  - When underflow_i=1 at cap, the stored product is {product_i[31], 31'b0}.
  - The stored underflow flag stays 1.
- Undefined: product_i is stored unmodified.
- sticky_o and drop_cnt_o behave identically in both builds.

Test Plan:
- Reset, then done_i pulses 3 cycles with product_i=32'h40C00000 (2.0*3.0) and flags 0 -> exactly one entry; count_o=1; valid_o=1 on the next cycle; data_o=40C00000; flags_o=0.
- Hold ready_i=0 and capture 9 results 32'h3F800000..+8 with DEPTH=8 -> full_o=1 after the 8th; the 9th is dropped; drop_cnt_o=1. Then set ready_i=1 -> 8 results pop in order with the first 3F800000; valid_o falls after the 8th.
- When full, issue cap and ready_i=1 in the same cycle -> count_o stays 8; head advances; the new value lands at the tail; drop_cnt_o unchanged.
- Capture 7F800000 with infinit_i=1, then 7FC00000 with nan_i=1 -> sticky_o=4'b1100. Pulse clr_sticky_i -> 0. Clear and cap overflow_i=1 in the same cycle -> sticky_o=4'b0010.
- Capture 32'h80000001 with underflow_i=1 -> data_o=80000000 with MUL32FP_FIFO_FTZ_EN, 80000001 without; flags_o=4'b0001 in both.
- Assert rst with 3 entries stored and done_i held high -> after rst falls, count_o=0, valid_o=0, and no capture until done_i drops and rises again.
